// File: rtl/gnn_pkg.sv
// Types and sizes shared by the weight loader, the weight buffer wrapper and the multiply stage.
package gnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam int WEIGHT_BEATS  = 16;
    localparam int BEAT_W        = 512;
    localparam int WEIGHT_ADDR_W = 13;

endpackage

// File: rtl/weight_loader_beat_packer.sv
// Collects BEATS stream beats into one word; beat 0 lands in the least-significant slice.
// The final beat is not stored: it is concatenated directly so the word is complete on the accept cycle.
module beat_packer
    import gnn_pkg::*;
#(
    parameter int DATA_W = BEAT_W,
    parameter int BEATS  = WEIGHT_BEATS
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     accept,
    input  logic [DATA_W-1:0]        data,
    output logic                     full,
    output logic [DATA_W*BEATS-1:0]  word
);

    localparam int CW = $clog2(BEATS);

    logic [CW-1:0]                 beat_cnt;
    logic [BEATS-2:0][DATA_W-1:0]  pack;

    assign full = accept && (beat_cnt == CW'(BEATS - 1));
    assign word = {data, pack};

    // BEATS is a power of two, so the counter wraps to 0 after the last beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (clr) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < BEATS - 1; k++) begin
            if (accept && beat_cnt == CW'(k)) begin
                pack[k] <= data;
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Loads number_of_words packed weight words into the weight buffer from a beat stream, one beat per cycle.
// Write lands one cycle after the last beat of a word, done one cycle later; s_ready is high only while loading.
module weight_loader
    import gnn_pkg::*;
#(
    parameter int DATA_W = BEAT_W,
    parameter int BEATS  = WEIGHT_BEATS,
    parameter int ADDR_W = WEIGHT_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start_valid,
    input  logic [ADDR_W-1:0]        weight_start_addr,
    input  logic [ADDR_W-1:0]        number_of_words,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W*BEATS-1:0]  wr_data,
    output logic                     busy,
    output logic                     done
);

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_W-1:0]          addr_reg;
    logic [ADDR_W-1:0]          words_left;
    logic                       accept;
    logic                       start_go;
    logic                       full;
    logic [DATA_W*BEATS-1:0]    word;

    assign s_ready  = (state == LOAD);
    assign busy     = (state != IDLE);
    assign accept   = s_valid && s_ready;
    assign start_go = (state == IDLE) && start_valid;

    beat_packer #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_packer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (start_go),
        .accept (accept),
        .data   (s_data),
        .full   (full),
        .word   (word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    state_nxt = (number_of_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (full && words_left == ADDR_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wr_data is its own register, so the packer can refill while the previous word is written.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            addr_reg   <= '0;
            words_left <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            wr_en <= full;
            done  <= (state == DONE);
            if (start_go) begin
                addr_reg   <= weight_start_addr;
                words_left <= number_of_words;
            end
            if (full) begin
                wr_addr    <= addr_reg;
                wr_data    <= word;
                addr_reg   <= addr_reg + 1'b1;
                words_left <= words_left - 1'b1;
            end
        end
    end

endmodule
